// File: rtl/smc_cfreg_bank.sv
`default_nettype none
// ============================================================================
// Module   : smc_cfreg_bank
// Brief    : Per-chip-select 32-bit config registers behind a zero-wait APB
//            slave. Shadow values are copied to the active set while the SMC
//            core is idle. Define SMC_CFG_LOCK_EN to add the key-lock FSM.
// Revision : 1.0 - initial release
// ============================================================================
module smc_cfreg_bank #(
    parameter int          NUM_CS  = 4,
    parameter int          ADDR_W  = 8,
    parameter logic [31:0] CFG_RST = 32'hC000_0001,
    parameter logic [31:0] WMASK   = 32'hFFFF_FFFF,
    parameter logic [31:0] ID_VAL  = 32'hC000_0001
) (
    input  logic                 hclk,
    input  logic                 sys_reset,
    input  logic                 psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [ADDR_W-1:0]    paddr,
    input  logic [31:0]          pwdata,
    output logic [31:0]          prdata,
    output logic                 pready,
    output logic                 pslverr,
    input  logic                 smc_idle,
    output logic [NUM_CS*32-1:0] cs_cfg,
    output logic                 cfg_update
);

    localparam int c_word_w = ADDR_W - 2;

    logic [c_word_w-1:0] w_word;
    logic                w_setup;
    logic                w_access;
    logic                w_is_id;
    logic                w_is_lock;
    logic                w_is_status;
    logic                w_is_cs;
    logic                w_unmapped;
    logic                w_locked;
    logic                w_err;
    logic                w_wr;
    logic                w_apply;
    logic [NUM_CS-1:0]   w_cs_hit;
    logic [NUM_CS-1:0]   w_cs_wr;
    logic [31:0]         w_new_val;
    logic [31:0]         w_status;
    logic [31:0]         w_rdata;
    logic                w_unused;

    logic [31:0]         r_shadow [NUM_CS];
    logic [31:0]         r_active [NUM_CS];
    logic [NUM_CS-1:0]   r_pending;
    logic [31:0]         r_prdata;
    logic                r_cfg_update;

    assign w_word      = paddr[ADDR_W-1:2];
    assign w_unused    = ^paddr[1:0];
    assign w_setup     = psel & ~penable;
    assign w_access    = psel & penable;
    assign w_is_id     = (w_word == c_word_w'(0));
    assign w_is_lock   = (w_word == c_word_w'(1));
    assign w_is_status = (w_word == c_word_w'(2));

    always_comb begin
        for (int n = 0; n < NUM_CS; n++) begin
            w_cs_hit[n] = (w_word == c_word_w'(n + 4));
        end
    end

    assign w_is_cs    = |w_cs_hit;
    assign w_unmapped = ~(w_is_id | w_is_lock | w_is_status | w_is_cs);

`ifdef SMC_CFG_LOCK_EN
    localparam logic [1:0] c_st_locked   = 2'd0;
    localparam logic [1:0] c_st_key1     = 2'd1;
    localparam logic [1:0] c_st_unlocked = 2'd2;

    logic [1:0] r_lock_st;

    // Any write while half-keyed (even one that errors) aborts the sequence.
    always_ff @(posedge hclk or posedge sys_reset) begin
        if (sys_reset) begin
            r_lock_st <= c_st_locked;
        end else if (w_access && pwrite) begin
            case (r_lock_st)
                c_st_locked: begin
                    if (w_is_lock && (pwdata == 32'h0000_005A)) r_lock_st <= c_st_key1;
                end
                c_st_key1: begin
                    r_lock_st <= (w_is_lock && (pwdata == 32'h0000_00A5)) ? c_st_unlocked : c_st_locked;
                end
                c_st_unlocked: begin
                    if (w_is_lock) r_lock_st <= c_st_locked;
                end
                default: r_lock_st <= c_st_locked;
            endcase
        end
    end

    assign w_locked = (r_lock_st != c_st_unlocked);
`else
    assign w_locked = 1'b0;
`endif

    assign w_err     = w_access & (w_unmapped
                                 | (pwrite & (w_is_id | w_is_status))
                                 | (pwrite & w_is_cs & w_locked));
    assign w_wr      = w_access & pwrite & ~w_err;
    assign w_cs_wr   = w_cs_hit & {NUM_CS{w_wr}};
    assign w_new_val = (pwdata & WMASK) | (CFG_RST & ~WMASK);
    assign w_apply   = smc_idle & (|r_pending);
    assign w_status  = {w_locked, {(31-NUM_CS){1'b0}}, r_pending};

    always_comb begin
        w_rdata = '0;
        if (w_is_id) begin
            w_rdata = ID_VAL;
        end else if (w_is_status) begin
            w_rdata = w_status;
        end
        for (int n = 0; n < NUM_CS; n++) begin
            if (w_cs_hit[n]) w_rdata = r_shadow[n];
        end
    end

    always_ff @(posedge hclk or posedge sys_reset) begin
        if (sys_reset) begin
            r_prdata <= '0;
        end else if (w_setup) begin
            r_prdata <= pwrite ? 32'h0 : w_rdata;
        end
    end

    // A write landing in the apply cycle re-arms its pending bit.
    always_ff @(posedge hclk or posedge sys_reset) begin
        if (sys_reset) begin
            for (int n = 0; n < NUM_CS; n++) begin
                r_shadow[n] <= CFG_RST;
                r_active[n] <= CFG_RST;
            end
            r_pending    <= '0;
            r_cfg_update <= 1'b0;
        end else begin
            r_cfg_update <= w_apply;
            r_pending    <= w_apply ? w_cs_wr : (r_pending | w_cs_wr);
            for (int n = 0; n < NUM_CS; n++) begin
                if (w_apply && r_pending[n]) r_active[n] <= r_shadow[n];
                if (w_cs_wr[n]) r_shadow[n] <= w_new_val;
            end
        end
    end

    for (genvar n = 0; n < NUM_CS; n++) begin : g_cs_out
        assign cs_cfg[32*n +: 32] = r_active[n];
    end

    assign prdata     = r_prdata;
    assign pready     = 1'b1;
    assign pslverr    = w_err;
    assign cfg_update = r_cfg_update;

endmodule
`default_nettype wire

// File: tb/tb_smc_cfreg_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_smc_cfreg_bank
// Brief    : Directed and random APB traffic against a behavioural register
//            model of smc_cfreg_bank (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_smc_cfreg_bank;

    localparam int          NCS  = 4;
    localparam logic [31:0] RSTV = 32'hC000_0001;
    localparam logic [31:0] MASK = 32'hFFFF_FFFF;
    localparam logic [31:0] IDV  = 32'hC000_0001;

    logic           hclk;
    logic           sys_reset;
    logic           psel;
    logic           penable;
    logic           pwrite;
    logic [7:0]     paddr;
    logic [31:0]    pwdata;
    logic [31:0]    prdata;
    logic           pready;
    logic           pslverr;
    logic           smc_idle;
    logic [NCS*32-1:0] cs_cfg;
    logic           cfg_update;

    smc_cfreg_bank #(
        .NUM_CS (NCS),
        .ADDR_W (8),
        .CFG_RST(RSTV),
        .WMASK  (MASK),
        .ID_VAL (IDV)
    ) dut (
        .hclk      (hclk),
        .sys_reset (sys_reset),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .smc_idle  (smc_idle),
        .cs_cfg    (cs_cfg),
        .cfg_update(cfg_update)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Reference model state: lock 0 = locked, 1 = key1, 2 = unlocked.
    logic [31:0]    m_shadow [NCS];
    logic [31:0]    m_active [NCS];
    logic [NCS-1:0] m_pending;
    int             m_lock;
    int             checks = 0;
    int             errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int n = 0; n < NCS; n++) begin
            m_shadow[n] = RSTV;
            m_active[n] = RSTV;
        end
        m_pending = '0;
`ifdef SMC_CFG_LOCK_EN
        m_lock = 0;
`else
        m_lock = 2;
`endif
    endtask

    function automatic int cs_of(input logic [7:0] a);
        int off;
        off = int'(a) & 32'hFC;
        if (off >= 16 && (off - 16) / 4 < NCS) return (off - 16) / 4;
        return -1;
    endfunction

    function automatic bit m_locked();
        return m_lock != 2;
    endfunction

    function automatic bit exp_err(input logic [7:0] a, input bit wr);
        int off;
        off = int'(a) & 32'hFC;
        if (off == 0 || off == 8) return wr;
        if (off == 4) return 1'b0;
        if (cs_of(a) >= 0) return wr && m_locked();
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [7:0] a);
        int off;
        off = int'(a) & 32'hFC;
        if (off == 0) return IDV;
        if (off == 8) return 32'(m_pending) | (m_locked() ? 32'h8000_0000 : 32'h0);
        if (cs_of(a) >= 0) return m_shadow[cs_of(a)];
        return 32'h0;
    endfunction

    function automatic logic [127:0] exp_cfg();
        logic [127:0] v;
        v = '0;
        for (int n = 0; n < NCS; n++) v[32*n +: 32] = m_active[n];
        return v;
    endfunction

    task automatic m_write(input logic [7:0] a, input logic [31:0] d);
        bit e;
        int off;
        int cs;
        e   = exp_err(a, 1'b1);
        off = int'(a) & 32'hFC;
        cs  = cs_of(a);
`ifdef SMC_CFG_LOCK_EN
        if (m_lock == 0) begin
            if (off == 4 && d == 32'h5A) m_lock = 1;
        end else if (m_lock == 1) begin
            m_lock = (off == 4 && d == 32'hA5) ? 2 : 0;
        end else if (off == 4) begin
            m_lock = 0;
        end
`endif
        if (!e && cs >= 0) begin
            m_shadow[cs]  = (d & MASK) | (RSTV & ~MASK);
            m_pending[cs] = 1'b1;
        end
    endtask

    task automatic m_apply();
        for (int n = 0; n < NCS; n++) begin
            if (m_pending[n]) m_active[n] = m_shadow[n];
        end
        m_pending = '0;
    endtask

    task automatic apb_wr(input logic [7:0] a, input logic [31:0] d, input string tag);
        bit e;
        e = exp_err(a, 1'b1);
        @(posedge hclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge hclk); #1;
        penable = 1'b1;
        #1 chk({tag, " wr err"}, 128'(pslverr), 128'(e));
        @(posedge hclk); #1;
        psel = 1'b0; penable = 1'b0;
        m_write(a, d);
    endtask

    task automatic apb_rd(input logic [7:0] a, input string tag);
        logic [31:0] ed;
        bit e;
        ed = exp_rd(a);
        e  = exp_err(a, 1'b0);
        @(posedge hclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge hclk); #1;
        penable = 1'b1;
        #1;
        chk({tag, " rdata"}, 128'(prdata), 128'(ed));
        chk({tag, " rd err"}, 128'(pslverr), 128'(e));
        @(posedge hclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic idle_pulse(input string tag);
        bit had;
        had = (m_pending != 0);
        @(posedge hclk); #1;
        smc_idle = 1'b1;
        @(posedge hclk); #1;
        smc_idle = 1'b0;
        m_apply();
        chk({tag, " update"}, 128'(cfg_update), 128'(had));
        chk({tag, " cs_cfg"}, cs_cfg, exp_cfg());
        @(posedge hclk); #1;
        chk({tag, " update drop"}, 128'(cfg_update), 128'(0));
    endtask

    initial begin
        logic [7:0]  a;
        logic [31:0] d;
        int          op;

        sys_reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; smc_idle = 1'b0;
        m_reset();
        repeat (3) @(posedge hclk);
        #1 sys_reset = 1'b0;

        chk("rst cs_cfg", cs_cfg, {4{32'hC000_0001}});
        chk("rst update", 128'(cfg_update), 128'(0));
        chk("rst pready", 128'(pready), 128'(1));
        apb_rd(8'h00, "rst id");
        apb_rd(8'h08, "rst status");
        apb_rd(8'h10, "rst cs0");

`ifdef SMC_CFG_LOCK_EN
        apb_wr(8'h10, 32'h1, "locked cs0");
        apb_wr(8'h04, 32'h5A, "key1");
        apb_wr(8'h04, 32'hA5, "key2");
        apb_wr(8'h10, 32'h1, "unlocked cs0");
        apb_rd(8'h08, "unlocked status");
        apb_wr(8'h04, 32'h0, "relock");
        apb_wr(8'h04, 32'h5A, "bad key1");
        apb_wr(8'h04, 32'h00, "bad key2");
        apb_rd(8'h08, "still locked");
        apb_wr(8'h10, 32'h3, "still locked cs0");
        apb_wr(8'h04, 32'h5A, "rekey1");
        apb_wr(8'h04, 32'hA5, "rekey2");
        idle_pulse("lock apply");
`endif

        // Hold-off, then apply on idle.
        apb_wr(8'h14, 32'h1234_5678, "cs1 wr");
        apb_rd(8'h08, "cs1 pending");
        chk("cs1 held", cs_cfg, exp_cfg());
        idle_pulse("cs1 apply");
        chk("cs1 value", cs_cfg[63:32], 128'(32'h1234_5678));
        apb_rd(8'h08, "cs1 cleared");

        // Write to the same CS in the apply cycle.
        apb_wr(8'h10, 32'h1111_1111, "cs0 first");
        @(posedge hclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10; pwdata = 32'hAA;
        @(posedge hclk); #1;
        penable = 1'b1; smc_idle = 1'b1;
        @(posedge hclk); #1;
        psel = 1'b0; penable = 1'b0; smc_idle = 1'b0;
        m_apply();
        m_write(8'h10, 32'hAA);
        chk("collide update", 128'(cfg_update), 128'(1));
        chk("collide old", cs_cfg[31:0], 128'(32'h1111_1111));
        apb_rd(8'h08, "collide pending");
        idle_pulse("collide apply");
        chk("collide new", cs_cfg[31:0], 128'(32'hAA));

        // Erroring accesses leave state alone.
        apb_wr(8'h00, 32'hDEAD_BEEF, "id wr");
        apb_wr(8'h08, 32'hFFFF_FFFF, "status wr");
        apb_rd(8'h40, "unmapped rd");
        apb_wr(8'h40, 32'h5555_5555, "unmapped wr");
        apb_rd(8'h0C, "hole rd");
        apb_rd(8'h08, "after err status");
        chk("after err cs_cfg", cs_cfg, exp_cfg());

        // Random traffic with idle held low except during explicit pulses.
        for (int i = 0; i < 250; i++) begin
            op = int'($urandom_range(0, 9));
            a  = 8'($urandom_range(0, 16) * 4) | 8'($urandom_range(0, 3));
            if (a[7:2] == 6'd16) a = 8'hFC;
            case ($urandom_range(0, 3))
                0:       d = 32'h5A;
                1:       d = 32'hA5;
                default: d = $urandom;
            endcase
            if (op <= 3)      apb_wr(a, d, "rand");
            else if (op <= 7) apb_rd(a, "rand");
            else              idle_pulse("rand");
        end
        idle_pulse("rand final");

        // Asynchronous reset with all CS pending.
        for (int n = 0; n < NCS; n++) apb_wr(8'(16 + 4 * n), $urandom, "pre rst");
        idle_pulse("pre rst");
        for (int n = 0; n < NCS; n++) apb_wr(8'(16 + 4 * n), $urandom, "pend rst");
        apb_rd(8'h08, "pend all");
        @(posedge hclk); #3;
        sys_reset = 1'b1;
        #1;
        m_reset();
        chk("async rst cs_cfg", cs_cfg, {4{32'hC000_0001}});
        @(posedge hclk); #1;
        sys_reset = 1'b0;
        smc_idle  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge hclk); #1;
            chk("post rst update", 128'(cfg_update), 128'(0));
        end
        smc_idle = 1'b0;
        apb_rd(8'h08, "post rst status");
        apb_rd(8'h1C, "post rst cs3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
